// File: rtl/sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_pkg
// Brief    : Gray-to-binary, popcount>1 helpers and stage limits
// Revision : 1.0 - initial release
// ============================================================================
package sync_pkg;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int PTR_W_MAX  = 32;

  // Upper zero bits do not disturb the conversion, so narrower pointers are
  // zero-extended into this width and truncated afterwards.
  function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] gray);
    logic [PTR_W_MAX-1:0] bin;
    bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic popcount_gt1(input logic [PTR_W_MAX-1:0] vec);
    return (vec & (vec - PTR_W_MAX'(1))) != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_chain
// Brief    : STAGES-deep flip-flop synchronizer, synchronous active-low reset
// Revision : 1.0 - initial release
// ============================================================================
module sync_chain
  import sync_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             D_CLK,
  input  logic             D_rst_n,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("sync_chain: STAGES out of legal range");
  end

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge D_CLK) begin
    if (!D_rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= Din;
      for (int k = 1; k < STAGES; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign Dout = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/gray_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module   : gray_ptr_sync
// Brief    : Gray pointer CDC synchronizer with binary output, change pulse
//            and optional multi-bit-change checker (GRAY_PTR_SYNC_CHECK_EN)
// Revision : 1.0 - initial release
// ============================================================================
module gray_ptr_sync
  import sync_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int STAGES     = 2
) (
  input  logic                D_CLK,
  input  logic                D_rst_n,
  input  logic [ADDR_WIDTH:0] Src_ptr_gray,
  input  logic                Err_clr,
  output logic [ADDR_WIDTH:0] Dq_ptr_gray,
  output logic [ADDR_WIDTH:0] Dq_ptr_bin,
  output logic                Ptr_chg,
  output logic                Sync_vld,
  output logic                Gray_err
);

  localparam int                 c_pw      = ADDR_WIDTH + 1;
  localparam int                 c_cnt_w   = $clog2(STAGES + 2);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(STAGES + 1);

  if (c_pw >= PTR_W_MAX) begin : g_bad_width
    $error("gray_ptr_sync: ADDR_WIDTH too large");
  end

  logic [c_pw-1:0]      w_sync_gray;
  logic [c_pw-1:0]      r_prev_gray;
  logic [c_pw-1:0]      r_bin;
  logic                 r_chg;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_vld;
  logic [PTR_W_MAX-1:0] w_bin_wide;
  logic                 w_unused_bin_hi;

  sync_chain #(
    .WIDTH  (c_pw),
    .STAGES (STAGES)
  ) u_sync_chain (
    .D_CLK   (D_CLK),
    .D_rst_n (D_rst_n),
    .Din     (Src_ptr_gray),
    .Dout    (w_sync_gray)
  );

  assign w_bin_wide      = gray2bin(PTR_W_MAX'(w_sync_gray));
  assign w_unused_bin_hi = |w_bin_wide[PTR_W_MAX-1:c_pw];
  assign w_vld           = (r_cnt == c_cnt_max);

  // Previous-value register and binary register update together, so the
  // change pulse lines up with the new binary value.
  always_ff @(posedge D_CLK) begin
    if (!D_rst_n) begin
      r_prev_gray <= '0;
      r_bin       <= '0;
      r_chg       <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_prev_gray <= w_sync_gray;
      r_bin       <= w_bin_wide[c_pw-1:0];
      r_chg       <= w_vld && (w_sync_gray != r_prev_gray);
      if (r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign Dq_ptr_gray = w_sync_gray;
  assign Dq_ptr_bin  = r_bin;
  assign Ptr_chg     = r_chg;
  assign Sync_vld    = w_vld;

`ifdef GRAY_PTR_SYNC_CHECK_EN
  logic [c_pw-1:0] w_delta;
  logic            w_err_set;
  logic            r_gray_err;

  assign w_delta   = w_sync_gray ^ r_prev_gray;
  assign w_err_set = w_vld && popcount_gt1(PTR_W_MAX'(w_delta));

  // A new violation takes priority over a coincident clear.
  always_ff @(posedge D_CLK) begin
    if (!D_rst_n) begin
      r_gray_err <= 1'b0;
    end else if (w_err_set) begin
      r_gray_err <= 1'b1;
    end else if (Err_clr) begin
      r_gray_err <= 1'b0;
    end
  end

  assign Gray_err = r_gray_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = Err_clr;
  assign Gray_err         = 1'b0;
`endif

endmodule
`default_nettype wire
